// File: rtl/alu_rsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rsp_pkg
//  Description : Shared opcode constants and FSM state encoding for the
//                bit-serial ALU responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_rsp_pkg;

  // Opcode encoding carried on the sel port
  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_ABSDIFF = 2'd1;
  localparam logic [1:0] OP_XOR3    = 2'd2;
  localparam logic [1:0] OP_AND3    = 2'd3;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bit_slice
//  Description : One bit of the serial datapath: full-add, both subtract
//                directions (a-b and b-a) with borrow, 3-input xor and and.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic carry_in,
  input  logic borrow_ab_in,
  input  logic borrow_ba_in,
  output logic sum,
  output logic carry_out,
  output logic diff_ab,
  output logic borrow_ab_out,
  output logic diff_ba,
  output logic borrow_ba_out,
  output logic xor3,
  output logic and3
);

  logic w_axb;

  // Pure combinational per-bit arithmetic and logic
  always_comb begin
    w_axb         = a ^ b;
    sum           = w_axb ^ carry_in;
    carry_out     = (a & b) | (carry_in & w_axb);
    diff_ab       = w_axb ^ borrow_ab_in;
    borrow_ab_out = (~a & b) | (~w_axb & borrow_ab_in);
    diff_ba       = w_axb ^ borrow_ba_in;
    borrow_ba_out = (~b & a) | (~w_axb & borrow_ba_in);
    xor3          = w_axb ^ c;
    and3          = a & b & c;
  end

endmodule
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_responder
//  Description : Request/response ALU that evaluates add, abs-difference,
//                xor3 or and3 bit-serially (LSB first, one bit per cycle).
//                Define ALU_RSP_CNT_EN to add the 8-bit op_cnt response
//                handshake counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_responder
  import alu_rsp_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W:0]   d,
  output logic         neg
`ifdef ALU_RSP_CNT_EN
  ,
  output logic [7:0]   op_cnt
`endif
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(W - 1);

  state_t         r_state;
  logic [1:0]     r_sel;
  logic [W-1:0]   r_a, r_b, r_c;
  logic [IW-1:0]  r_idx;
  logic           r_carry, r_borrow_ab, r_borrow_ba;
  logic [W-1:0]   r_sum, r_dab, r_dba, r_x3, r_and3;
  logic [W:0]     r_d;
  logic           r_neg, r_rsp_valid, r_req_ready;

  logic           w_sum, w_cout, w_dab, w_bab, w_dba, w_bba, w_x3, w_and3;
  logic [W-1:0]   w_sum_n, w_dab_n, w_dba_n, w_x3_n, w_and3_n;

  alu_bit_slice u_slice (
    .a             (r_a[r_idx]),
    .b             (r_b[r_idx]),
    .c             (r_c[r_idx]),
    .carry_in      (r_carry),
    .borrow_ab_in  (r_borrow_ab),
    .borrow_ba_in  (r_borrow_ba),
    .sum           (w_sum),
    .carry_out     (w_cout),
    .diff_ab       (w_dab),
    .borrow_ab_out (w_bab),
    .diff_ba       (w_dba),
    .borrow_ba_out (w_bba),
    .xor3          (w_x3),
    .and3          (w_and3)
  );

  // Partial results with the current bit merged in, so the last EXEC edge
  // can load the final result directly
  always_comb begin
    w_sum_n         = r_sum;
    w_dab_n         = r_dab;
    w_dba_n         = r_dba;
    w_x3_n          = r_x3;
    w_and3_n        = r_and3;
    w_sum_n[r_idx]  = w_sum;
    w_dab_n[r_idx]  = w_dab;
    w_dba_n[r_idx]  = w_dba;
    w_x3_n[r_idx]   = w_x3;
    w_and3_n[r_idx] = w_and3;
  end

  // Control FSM, serial datapath state and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_borrow_ab <= 1'b0;
      r_borrow_ba <= 1'b0;
      r_sum       <= '0;
      r_dab       <= '0;
      r_dba       <= '0;
      r_x3        <= '0;
      r_and3      <= '0;
      r_d         <= '0;
      r_neg       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_sel       <= sel;
            r_a         <= a;
            r_b         <= b;
            r_c         <= c;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_borrow_ab <= 1'b0;
            r_borrow_ba <= 1'b0;
            r_sum       <= '0;
            r_dab       <= '0;
            r_dba       <= '0;
            r_x3        <= '0;
            r_and3      <= '0;
            r_req_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_sum       <= w_sum_n;
          r_dab       <= w_dab_n;
          r_dba       <= w_dba_n;
          r_x3        <= w_x3_n;
          r_and3      <= w_and3_n;
          r_carry     <= w_cout;
          r_borrow_ab <= w_bab;
          r_borrow_ba <= w_bba;
          r_idx       <= r_idx + IW'(1);
          if (r_idx == C_LAST_IDX) begin
            // Final borrow out of a-b tells whether a<b
            case (r_sel)
              OP_ADD: begin
                r_d   <= {w_cout, w_sum_n};
                r_neg <= 1'b0;
              end
              OP_ABSDIFF: begin
                r_d   <= w_bab ? {1'b0, w_dba_n} : {1'b0, w_dab_n};
                r_neg <= w_bab;
              end
              OP_XOR3: begin
                r_d   <= {1'b0, w_x3_n};
                r_neg <= 1'b0;
              end
              default: begin
                r_d   <= {1'b0, w_and3_n};
                r_neg <= 1'b0;
              end
            endcase
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_RSP_CNT_EN
  logic [7:0] r_op_cnt;

  // Count completed response handshakes, wrapping naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt <= '0;
    end else if (r_rsp_valid && rsp_ready) begin
      r_op_cnt <= r_op_cnt + 8'd1;
    end
  end

  assign op_cnt = r_op_cnt;
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign d         = r_d;
  assign neg       = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_responder
//  Description : Self-checking bench for alu_responder with directed and
//                random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   sel;
  logic [W-1:0] a, b, c;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W:0]   d;
  logic         neg;
`ifdef ALU_RSP_CNT_EN
  logic [7:0]   op_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_responder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .c         (c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .d         (d),
    .neg       (neg)
`ifdef ALU_RSP_CNT_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode definitions
  function automatic int model_d(input int s, input int x, input int y, input int z);
    case (s)
      0:       return x + y;
      1:       return (x >= y) ? x - y : y - x;
      2:       return x ^ y ^ z;
      default: return x & y & z;
    endcase
  endfunction

  function automatic int model_neg(input int s, input int x, input int y);
    return (s == 1 && x < y) ? 1 : 0;
  endfunction

  // One full transaction; called and returning at a negedge
  task automatic run_op(input int s, input int x, input int y, input int z,
                        input int bp, input bit scramble, input bit verbose);
    int n;
    int ed, en;
    ed = model_d(s, x, y, z);
    en = model_neg(s, x, y);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    sel = 2'(s); a = W'(x); b = W'(y); c = W'(z);
    req_valid = 1'b1;
    @(negedge clk);            // acceptance edge N has passed
    req_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (scramble) begin
        sel = 2'($urandom); a = W'($urandom); b = W'($urandom); c = W'($urandom);
        req_valid = 1'b1;
      end
      if (verbose) begin
        chk("rsp_valid_pre", 32'(rsp_valid), 32'd0);
        chk("req_ready_exec", 32'(req_ready), 32'd0);
      end
      @(negedge clk);          // after edge N+k
    end
    req_valid = 1'b0;
    chk("rsp_valid_at_N+W", 32'(rsp_valid), 32'd1);
    chk("d", 32'(d), 32'(ed));
    chk("neg", 32'(neg), 32'(en));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_d", 32'(d), 32'(ed));
      chk("bp_neg", 32'(neg), 32'(en));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (verbose) begin
      chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
      chk("req_ready_back", 32'(req_ready), 32'd1);
      chk("d_held_idle", 32'(d), 32'(ed));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    sel = '0; a = '0; b = '0; c = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
`ifdef ALU_RSP_CNT_EN
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed cases
    run_op(0, 7, 7, 0, 0, 1'b0, 1'b1);   // d=14, neg=0, valid at N+3
    run_op(1, 4, 7, 0, 0, 1'b0, 1'b1);   // d=3, neg=1
    run_op(1, 6, 2, 0, 0, 1'b0, 1'b1);   // d=4, neg=0
    run_op(2, 4, 6, 5, 0, 1'b0, 1'b1);   // d=7
    run_op(3, 3, 2, 7, 0, 1'b0, 1'b1);   // d=2
    // Backpressure with operand churn during EXEC
    run_op(1, 1, 6, 3, 5, 1'b1, 1'b1);

    // Reset during the second EXEC cycle
    sel = 2'd0; a = 3'd3; b = 3'd3; c = 3'd0;
    req_valid = 1'b1;
    @(negedge clk);                       // accepted
    req_valid = 1'b0;
    @(posedge clk);                       // first EXEC edge
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    chk("midrst_neg", 32'(neg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    run_op(0, 2, 5, 0, 0, 1'b0, 1'b1);   // d=7

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
    end

`ifdef ALU_RSP_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             0, 1'b0, 1'b0);
    end
    chk("op_cnt_wrap", 32'(op_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_responder.md
ALU_RESPONDER -- requirements
Module: alu_responder

Interface
REQ-001 SHALL have parameter W, default 3, operand width in bits; also the number of serial execute cycles.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request.
REQ-006 SHALL have port sel  input  2  opcode: 0 add, 1 abs-difference, 2 xor3, 3 and3.
REQ-007 SHALL have ports a, b, c  input  W each  operands; c is used by sel 2/3 only.
REQ-008 SHALL have port rsp_valid  output  1  result present.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port d  output  W+1  result.
REQ-011 SHALL have port neg  output  1  set when sel=1 and a<b.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-013 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-014 SHALL capture sel, a, b, c at acceptance; later input changes SHALL NOT affect the result.
REQ-015 SHALL process operands bit-serially LSB first in EXEC, one bit per cycle, for exactly W cycles, using a registered bit index and registered carry/borrow.
REQ-016 SHALL, for sel=0, produce d = a+b, with the final carry as d[W]; neg=0.
REQ-017 SHALL, for sel=1, run a-b and b-a borrow chains in parallel; neg=1 and d=b-a when a<b, else neg=0 and d=a-b; d[W]=0.
REQ-018 SHALL, for sel=2, produce d = {0, a^b^c}; for sel=3, d = {0, a&b&c}; neg=0.
REQ-019 SHALL enter DONE and assert rsp_valid exactly W cycles after the acceptance edge.
REQ-020 SHALL hold d, neg and rsp_valid stable in DONE until an edge with rsp_ready=1; that edge SHALL return the FSM to IDLE with rsp_valid=0.
REQ-021 SHALL NOT accept a request in the cycle rsp_valid is being cleared (no overlap); earliest next acceptance is the following edge.
REQ-022 SHALL keep d and neg at their last values while in IDLE and EXEC.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-EXEC, force IDLE, req_ready=1 once released, rsp_valid=0, d=0, neg=0, bit index 0, carry/borrow 0, and discard any operation in flight.

Configuration
REQ-024 SHALL, when ALU_RSP_CNT_EN is defined, add output op_cnt (8 bits, reset 0) incremented on each response handshake (rsp_valid && rsp_ready), wrapping 255 -> 0.
REQ-025 SHALL, when ALU_RSP_CNT_EN is undefined, have no op_cnt port or counter logic; all other behaviour identical.

Structure
REQ-026 SHALL place the opcode constants (OP_ADD, OP_ABSDIFF, OP_XOR3, OP_AND3) and the FSM state encoding in shared package alu_rsp_pkg.
REQ-027 SHALL use one sub-module, alu_bit_slice, computing a single bit's sum/diff/xor/and outputs plus carry/borrow out from carry/borrow in.

Verification
REQ-028 SHALL test sel=0, a=7, b=7 accepted at edge N -> rsp_valid rises at edge N+3, d=14, neg=0.
REQ-029 SHALL test sel=1, a=4, b=7 -> d=3, neg=1; then sel=1, a=6, b=2 -> d=4, neg=0.
REQ-030 SHALL test sel=2, a=4, b=6, c=5 -> d=7; and sel=3, a=3, b=2, c=7 -> d=2; both with neg=0.
REQ-031 SHALL test backpressure: rsp_ready=0 for 5 cycles after the result -> rsp_valid, d and neg held, req_ready=0 throughout, operand changes during EXEC ignored.
REQ-032 SHALL test reset mid-operation: rst_n=0 during EXEC cycle 2 -> rsp_valid=0, d=0 immediately; a new sel=0, a=2, b=5 request after release -> d=7.
REQ-033 SHALL, with ALU_RSP_CNT_EN defined, run 257 back-to-back requests -> op_cnt=1.
